ex_muldiv_unit: RTL and testbench

//  Parametrised multi-cycle multiply / multiply-accumulate / divide engine for the EX stage.

---
 rtl/ex_muldiv_unit.sv | 186 ++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle MULT/MADD/MSUB/DIV engine for the EX stage; {HI,LO} result on result_o.
// Define MULDIV_DIV_EN to build the restoring divider; otherwise DIV/DIVU return 0.
module ex_muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [2:0]         op_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic [2*WIDTH-1:0] hilo_i,
  input  logic               cancel_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               stallreq_o
);

  localparam int unsigned W2 = 2 * WIDTH;
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] MUL  = 3'd1;
  localparam logic [2:0] ACC  = 3'd2;
  localparam logic [2:0] DONE = 3'd4;
`ifdef MULDIV_DIV_EN
  localparam logic [2:0] DIV  = 3'd3;
  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CntLast = CW'(WIDTH - 1);
`endif

  logic [2:0]       state_q, state_d;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [W2-1:0]    hilo_q, prod_q, prod_d, result_q, result_d;
  logic             accept, op_signed, op_acc, in_op;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [W2-1:0]    prod_mag, product;

  assign accept    = (state_q == IDLE) && start_i && !cancel_i;
  assign op_signed = ~op_q[0];
  assign op_acc    = op_q[2] ^ op_q[1];

  // Multiply on magnitudes; restore the sign afterwards.
  assign a_neg    = op_signed & a_q[WIDTH-1];
  assign b_neg    = op_signed & b_q[WIDTH-1];
  assign a_mag    = a_neg ? -a_q : a_q;
  assign b_mag    = b_neg ? -b_q : b_q;
  assign prod_mag = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
  assign product  = (a_neg ^ b_neg) ? -prod_mag : prod_mag;

`ifdef MULDIV_DIV_EN
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q, rem_fix, quo_fix;
  logic [CW-1:0]    cnt_q;
  logic             fix_q, qneg_q, rneg_q;
  logic             dvd_neg, dvs_neg;
  logic [WIDTH:0]   rem_sh, diff;

  assign dvd_neg = ~op_i[0] & opdata1_i[WIDTH-1];
  assign dvs_neg = ~op_i[0] & opdata2_i[WIDTH-1];
  assign rem_sh  = {rem_q, quo_q[WIDTH-1]};
  assign diff    = rem_sh - {1'b0, dvs_q};
  assign rem_fix = rneg_q ? -rem_q : rem_q;
  assign quo_fix = qneg_q ? -quo_q : quo_q;

  // After the last step one extra cycle applies the sign fix-up.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      fix_q  <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else if (accept && (op_i[2:1] == 2'b11)) begin
      rem_q  <= '0;
      quo_q  <= dvd_neg ? -opdata1_i : opdata1_i;
      dvs_q  <= dvs_neg ? -opdata2_i : opdata2_i;
      cnt_q  <= '0;
      fix_q  <= 1'b0;
      qneg_q <= dvd_neg ^ dvs_neg;
      rneg_q <= dvd_neg;
    end else if ((state_q == DIV) && !cancel_i && !fix_q) begin
      if (!diff[WIDTH]) begin
        rem_q <= diff[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_q <= rem_sh[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
      end
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == CntLast) fix_q <= 1'b1;
    end
  end

  assign in_op = (state_q == MUL) || (state_q == ACC) || (state_q == DIV);
`else
  assign in_op = (state_q == MUL) || (state_q == ACC);
`endif

  always_comb begin
    state_d  = state_q;
    prod_d   = prod_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (op_i[2:1] == 2'b11) begin
`ifdef MULDIV_DIV_EN
            if (opdata2_i == '0) begin
              state_d  = DONE;
              result_d = {opdata1_i, {WIDTH{1'b1}}};
            end else begin
              state_d = DIV;
            end
`else
            state_d  = DONE;
            result_d = '0;
`endif
          end else begin
            state_d = MUL;
          end
        end
      end
      MUL: begin
        if (cancel_i) begin
          state_d = IDLE;
        end else if (op_acc) begin
          prod_d  = product;
          state_d = ACC;
        end else begin
          result_d = product;
          state_d  = DONE;
        end
      end
      ACC: begin
        if (cancel_i) begin
          state_d = IDLE;
        end else begin
          result_d = op_q[2] ? (hilo_q - prod_q) : (hilo_q + prod_q);
          state_d  = DONE;
        end
      end
`ifdef MULDIV_DIV_EN
      DIV: begin
        if (cancel_i) begin
          state_d = IDLE;
        end else if (fix_q) begin
          result_d = {rem_fix, quo_fix};
          state_d  = DONE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      hilo_q   <= '0;
      prod_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      prod_q   <= prod_d;
      result_q <= result_d;
      if (accept) begin
        op_q   <= op_i;
        a_q    <= opdata1_i;
        b_q    <= opdata2_i;
        hilo_q <= hilo_i;
      end
    end
  end

  assign result_o   = result_q;
  assign ready_o    = (state_q == DONE);
  assign busy_o     = (state_q != IDLE);
  assign stallreq_o = rst && (accept || in_op);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed-vector bench for ex_muldiv_unit (WIDTH=32); DIV expectations follow MULDIV_DIV_EN.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] d1 = '0, d2 = '0;
  logic [63:0] hilo = '0;
  logic        cancel = 1'b0;
  logic [63:0] result;
  logic        ready, busy, stall;

  int tests = 0;
  int fails = 0;

  ex_muldiv_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start),
    .op_i       (op),
    .opdata1_i  (d1),
    .opdata2_i  (d2),
    .hilo_i     (hilo),
    .cancel_i   (cancel),
    .result_o   (result),
    .ready_o    (ready),
    .busy_o     (busy),
    .stallreq_o (stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op, wait for ready; lat counts edges from the accept edge, stc counts stall cycles.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] h, output int lat, output int stc);
    @(negedge clk);
    start = 1'b1; op = o; d1 = a; d2 = b; hilo = h;
    #1 stc = stall ? 1 : 0;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (ready) begin
        lat = k;
        break;
      end
      if (stall) stc++;
    end
  endtask

  task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] h, input logic [63:0] exp_res,
                       input int exp_lat, output int stc);
    int lat;
    run_op(o, a, b, h, lat, stc);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_res"}, result, exp_res);
    check({tag, "_stall_done"}, 64'(stall), 64'd0);
    @(negedge clk);
    check({tag, "_ready_pulse"}, 64'(ready), 64'd0);
    check({tag, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int          stc, rdy_cnt;
    logic [63:0] prev;

    #12;
    check("reset_result", result, 64'd0);
    check("reset_ready", 64'(ready), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_stall", 64'(stall), 64'd0);
    rst = 1'b1;

    do_op("mult", 3'd0, 32'hFFFFFFFD, 32'h5, 64'd0, 64'hFFFFFFFF_FFFFFFF1, 2, stc);
    do_op("maddu", 3'd3, 32'h10, 32'h10, 64'h00000001_FFFFFFFF, 64'h00000002_000000FF, 3, stc);
    do_op("msub", 3'd4, 32'd2, 32'd3, 64'd0, 64'hFFFFFFFF_FFFFFFFA, 3, stc);
    check("msub_stall_cycles", 64'(stc), 64'd3);
    do_op("mult_minneg", 3'd0, 32'h80000000, 32'h80000000, 64'd0, 64'h40000000_00000000, 2, stc);
    do_op("madd_neg", 3'd2, 32'hFFFFFFFF, 32'd4, 64'd10, 64'd6, 3, stc);

`ifdef MULDIV_DIV_EN
    do_op("div", 3'd6, 32'hFFFFFFF9, 32'h2, 64'd0, 64'hFFFFFFFF_FFFFFFFD, 34, stc);
    do_op("divu", 3'd7, 32'h80000000, 32'h3, 64'd0, 64'h00000002_2AAAAAAA, 34, stc);
    do_op("div_minneg", 3'd6, 32'h80000000, 32'hFFFFFFFF, 64'd0, 64'h00000000_80000000, 34, stc);
    do_op("divu_by0", 3'd7, 32'h12345678, 32'h0, 64'd0, 64'h12345678_FFFFFFFF, 1, stc);
`else
    do_op("div", 3'd6, 32'hFFFFFFF9, 32'h2, 64'd0, 64'd0, 1, stc);
    do_op("divu", 3'd7, 32'h80000000, 32'h3, 64'd0, 64'd0, 1, stc);
    do_op("divu_by0", 3'd7, 32'h12345678, 32'h0, 64'd0, 64'd0, 1, stc);
    do_op("mult_set", 3'd0, 32'd5, 32'd5, 64'd0, 64'd25, 2, stc);
`endif

    // Cancel mid-op: no ready, result unchanged.
    prev = result;
    rdy_cnt = 0;
    @(negedge clk);
`ifdef MULDIV_DIV_EN
    start = 1'b1; op = 3'd6; d1 = 32'd1000; d2 = 32'd7;
`else
    start = 1'b1; op = 3'd2; d1 = 32'd1000; d2 = 32'd7; hilo = 64'd1;
`endif
    @(posedge clk);
    #1 start = 1'b0;
`ifdef MULDIV_DIV_EN
    repeat (11) begin
`else
    repeat (1) begin
`endif
      @(negedge clk);
      if (ready) rdy_cnt++;
    end
    cancel = 1'b1;
    @(posedge clk);
    #1 cancel = 1'b0;
    @(negedge clk);
    check("cancel_busy", 64'(busy), 64'd0);
    check("cancel_stall", 64'(stall), 64'd0);
    repeat (40) begin
      @(negedge clk);
      if (ready) rdy_cnt++;
    end
    check("cancel_no_ready", 64'(rdy_cnt), 64'd0);
    check("cancel_result", result, prev);

    do_op("multu", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd0, 64'hFFFFFFFE_00000001, 2, stc);

    // Cancel and start together in IDLE: nothing accepted.
    @(negedge clk);
    start = 1'b1; cancel = 1'b1; op = 3'd0; d1 = 32'd9; d2 = 32'd9;
    #1 check("cancel_start_stall", 64'(stall), 64'd0);
    @(posedge clk);
    #1 begin start = 1'b0; cancel = 1'b0; end
    @(negedge clk);
    check("cancel_start_busy", 64'(busy), 64'd0);

    // Cancel during DONE still completes.
    @(negedge clk);
    start = 1'b1; op = 3'd1; d1 = 32'd3; d2 = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 cancel = 1'b1;
    @(negedge clk);
    check("cancel_done_ready", 64'(ready), 64'd1);
    check("cancel_done_res", result, 64'd9);
    @(posedge clk);
    #1 cancel = 1'b0;

    // Start and operand changes mid-op are ignored.
    @(negedge clk);
    start = 1'b1; op = 3'd0; d1 = 32'd2; d2 = 32'd3;
    @(posedge clk);
    #1 begin op = 3'd1; d1 = 32'd7; d2 = 32'd7; end
    @(negedge clk);
    check("ignore_busy", 64'(busy), 64'd1);
    @(negedge clk);
    check("ignore_ready", 64'(ready), 64'd1);
    check("ignore_res", result, 64'd6);
    start = 1'b0;
    @(negedge clk);

    // Asynchronous reset mid-MADD.
    @(negedge clk);
    start = 1'b1; op = 3'd2; d1 = 32'd4; d2 = 32'd4; hilo = 64'd1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_result", result, 64'd0);
    check("rst_mid_ready", 64'(ready), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_stall", 64'(stall), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    do_op("mult_after_rst", 3'd0, 32'd7, 32'hFFFFFFFF, 64'd0, 64'hFFFFFFFF_FFFFFFF9, 2, stc);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
